// File: rtl/sdram_cmd_engine.sv
// SDRAM command/data engine: issues one SDRAM command sequence per accepted request,
// with NOP spacing from the timing parameters, and streams write/read beats.
module sdram_cmd_engine #(
    parameter int unsigned DATAWIDTH = 32,
    parameter int unsigned ROWWIDTH  = 13,
    parameter int unsigned COLWIDTH  = 9,
    parameter int unsigned BANKWIDTH = 2,
    parameter int unsigned TRCD      = 2,
    parameter int unsigned TRP       = 2,
    parameter int unsigned TMRD      = 2,
    parameter int unsigned TWR       = 2,
    parameter int unsigned TRFC      = 7
) (
    input  logic                   Clk,
    input  logic                   Rest,
    input  logic                   ReqValid,
    output logic                   ReqReady,
    input  logic [2:0]             ReqOp,
    input  logic [BANKWIDTH-1:0]   ReqBank,
    input  logic [ROWWIDTH-1:0]    ReqAddr,
    input  logic                   ReqAutoPre,
    input  logic [COLWIDTH:0]      ReqLen,
    output logic                   Done,
    output logic                   WrDataReady,
    input  logic [DATAWIDTH-1:0]   WrData,
    input  logic [DATAWIDTH/8-1:0] WrMask,
    output logic                   RdDataValid,
    output logic [DATAWIDTH-1:0]   RdData,
    input  logic [DATAWIDTH-1:0]   SdramToChipDqIn,
    output logic [3:0]             SdramToChipCmd,
    output logic [ROWWIDTH-1:0]    SdramToChipArg,
    output logic [BANKWIDTH-1:0]   SdramToChipBan,
    output logic [DATAWIDTH-1:0]   SdramToChipDq,
    output logic [DATAWIDTH/8-1:0] SdramToChipDqm,
    output logic                   SdramDqOe
);

    localparam logic [3:0] CmdMrs = 4'b0000;
    localparam logic [3:0] CmdRef = 4'b0001;
    localparam logic [3:0] CmdPre = 4'b0010;
    localparam logic [3:0] CmdAct = 4'b0011;
    localparam logic [3:0] CmdWr  = 4'b0100;
    localparam logic [3:0] CmdRd  = 4'b0101;
    localparam logic [3:0] CmdBst = 4'b0110;
    localparam logic [3:0] CmdNop = 4'b0111;

    // Last cycle index of each fixed-length state
    localparam logic [15:0] LastMrs = 16'(TMRD - 1);
    localparam logic [15:0] LastPre = 16'(TRP - 1);
    localparam logic [15:0] LastAct = 16'(TRCD - 1);
    localparam logic [15:0] LastRef = 16'(TRFC - 1);
    localparam logic [15:0] LastWr  = 16'(TWR - 1);

    typedef enum logic [3:0] {
        StIdle, StMrs, StPre, StAct, StRef, StWr, StWrRec, StRd, StBst, StAPre
    } state_t;

    state_t                 state, stateD;
    logic [15:0]            cnt, cntD, last, lastD;
    logic [ROWWIDTH-1:0]    addr, addrD;
    logic [BANKWIDTH-1:0]   bank, bankD;
    logic                   autoPre, autoPreD;
    logic [COLWIDTH:0]      len, lenD;
    logic [2:0]             modeBl, modeBlD, modeCl, modeClD;

    logic                   accept, fullPage, isFinal;
    logic [15:0]            beats, casLat;
    logic [ROWWIDTH-1:0]    colArg, preArg;
    logic [3:0]             cmdD;
    logic [ROWWIDTH-1:0]    argD;
    logic [BANKWIDTH-1:0]   banD;
    logic                   doneD, wrRdyD, rdValidD;

    function automatic logic [15:0] burstBeats(input logic [2:0] bl, input logic [COLWIDTH:0] n);
        case (bl)
            3'b000:  return 16'd1;
            3'b001:  return 16'd2;
            3'b010:  return 16'd4;
            3'b011:  return 16'd8;
            3'b111:  return (n == '0) ? 16'd1 : 16'(n);
            default: return 16'd1;
        endcase
    endfunction

    assign ReqReady       = (state == StIdle) && !Rest;
    assign accept         = ReqValid && ReqReady;
    // Write beats pass straight from the FWFT FIFO head; read beats straight from the pins
    assign SdramToChipDq  = WrDataReady ? WrData : '0;
    assign SdramToChipDqm = WrDataReady ? WrMask : '0;
    assign RdData         = RdDataValid ? SdramToChipDqIn : '0;

    // Next-state, request latching and next-cycle output values
    always_comb begin
        stateD   = state;
        cntD     = cnt + 16'd1;
        lastD    = last;
        addrD    = addr;
        bankD    = bank;
        autoPreD = autoPre;
        lenD     = len;
        modeBlD  = modeBl;
        modeClD  = modeCl;

        if (accept) begin
            addrD    = ReqAddr;
            bankD    = ReqBank;
            lenD     = ReqLen;
            // Full-page bursts end with BST, so auto-precharge is never encoded for them
            autoPreD = ReqAutoPre && (modeBl != 3'b111);
            if (ReqOp == 3'd0) begin
                modeBlD = ReqAddr[2:0];
                modeClD = ReqAddr[6:4];
            end
        end

        fullPage = (modeBlD == 3'b111);
        beats    = burstBeats(modeBlD, lenD);
        casLat   = (modeClD == 3'b011) ? 16'd3 : 16'd2;

        case (state)
            StIdle: begin
                cntD = '0;
                if (accept) begin
                    case (ReqOp)
                        3'd0: begin stateD = StMrs; lastD = LastMrs; end
                        3'd1: begin stateD = StPre; lastD = LastPre; end
                        3'd2: begin stateD = StAct; lastD = LastAct; end
                        3'd3: begin stateD = StRd;  lastD = casLat + beats - 16'd1; end
                        3'd4: begin stateD = StWr;  lastD = beats - 16'd1; end
                        3'd5: begin stateD = StRef; lastD = LastRef; end
                        // Reserved: one silent cycle carrying Done
                        default: begin stateD = StAPre; lastD = '0; end
                    endcase
                end
            end
            default: begin
                if (cnt == last) begin
                    cntD = '0;
                    case (state)
                        StWr: begin
                            if (fullPage) begin stateD = StBst;   lastD = '0; end
                            else          begin stateD = StWrRec; lastD = LastWr; end
                        end
                        StBst: begin stateD = StWrRec; lastD = LastWr; end
                        StWrRec, StRd: begin
                            if (autoPreD) begin stateD = StAPre; lastD = LastPre; end
                            else          stateD = StIdle;
                        end
                        default: stateD = StIdle;
                    endcase
                end
            end
        endcase

        colArg                 = '0;
        colArg[COLWIDTH-1:0]   = addrD[COLWIDTH-1:0];
        colArg[10]             = autoPreD;
        preArg                 = '0;
        preArg[10]             = 1'b1;

        cmdD = CmdNop;
        argD = '0;
        banD = '0;
        if (cntD == '0) begin
            case (stateD)
                StMrs: begin cmdD = CmdMrs; argD = addrD; end
                StPre: begin cmdD = CmdPre; argD = preArg; end
                StAct: begin cmdD = CmdAct; argD = addrD;  banD = bankD; end
                StRef: cmdD = CmdRef;
                StWr:  begin cmdD = CmdWr;  argD = colArg; banD = bankD; end
                StRd:  begin cmdD = CmdRd;  argD = colArg; banD = bankD; end
                StBst: cmdD = CmdBst;
                default: cmdD = CmdNop;
            endcase
        end
        // Full-page read stops the burst right after the last column is addressed
        if (stateD == StRd && fullPage && cntD == beats) begin
            cmdD = CmdBst;
        end

        wrRdyD   = (stateD == StWr);
        rdValidD = (stateD == StRd) && (cntD >= casLat);

        case (stateD)
            StMrs, StPre, StAct, StRef, StAPre: isFinal = 1'b1;
            StWrRec, StRd:                      isFinal = !autoPreD;
            default:                            isFinal = 1'b0;
        endcase
        doneD = isFinal && (cntD == lastD);
    end

    // State, latched request and registered pin/handshake outputs
    always_ff @(posedge Clk) begin
        if (Rest) begin
            state          <= StIdle;
            cnt            <= '0;
            last           <= '0;
            addr           <= '0;
            bank           <= '0;
            autoPre        <= 1'b0;
            len            <= '0;
            modeBl         <= '0;
            modeCl         <= '0;
            SdramToChipCmd <= CmdNop;
            SdramToChipArg <= '0;
            SdramToChipBan <= '0;
            Done           <= 1'b0;
            WrDataReady    <= 1'b0;
            SdramDqOe      <= 1'b0;
            RdDataValid    <= 1'b0;
        end else begin
            state          <= stateD;
            cnt            <= cntD;
            last           <= lastD;
            addr           <= addrD;
            bank           <= bankD;
            autoPre        <= autoPreD;
            len            <= lenD;
            modeBl         <= modeBlD;
            modeCl         <= modeClD;
            SdramToChipCmd <= cmdD;
            SdramToChipArg <= argD;
            SdramToChipBan <= banD;
            Done           <= doneD;
            WrDataReady    <= wrRdyD;
            SdramDqOe      <= wrRdyD;
            RdDataValid    <= rdValidD;
        end
    end

endmodule

// File: tb/tb_sdram_cmd_engine.sv
// Directed bench for sdram_cmd_engine: per-operation cycle masks against hand-computed values.
module tb_sdram_cmd_engine;

    logic        Clk = 1'b0;
    logic        Rest;
    logic        ReqValid;
    logic        ReqReady;
    logic [2:0]  ReqOp;
    logic [1:0]  ReqBank;
    logic [12:0] ReqAddr;
    logic        ReqAutoPre;
    logic [9:0]  ReqLen;
    logic        Done;
    logic        WrDataReady;
    logic [31:0] WrData;
    logic [3:0]  WrMask;
    logic        RdDataValid;
    logic [31:0] RdData;
    logic [31:0] SdramToChipDqIn;
    logic [3:0]  SdramToChipCmd;
    logic [12:0] SdramToChipArg;
    logic [1:0]  SdramToChipBan;
    logic [31:0] SdramToChipDq;
    logic [3:0]  SdramToChipDqm;
    logic        SdramDqOe;

    sdram_cmd_engine dut (
        .Clk             (Clk),
        .Rest            (Rest),
        .ReqValid        (ReqValid),
        .ReqReady        (ReqReady),
        .ReqOp           (ReqOp),
        .ReqBank         (ReqBank),
        .ReqAddr         (ReqAddr),
        .ReqAutoPre      (ReqAutoPre),
        .ReqLen          (ReqLen),
        .Done            (Done),
        .WrDataReady     (WrDataReady),
        .WrData          (WrData),
        .WrMask          (WrMask),
        .RdDataValid     (RdDataValid),
        .RdData          (RdData),
        .SdramToChipDqIn (SdramToChipDqIn),
        .SdramToChipCmd  (SdramToChipCmd),
        .SdramToChipArg  (SdramToChipArg),
        .SdramToChipBan  (SdramToChipBan),
        .SdramToChipDq   (SdramToChipDq),
        .SdramToChipDqm  (SdramToChipDqm),
        .SdramDqOe       (SdramDqOe)
    );

    always #5 Clk = ~Clk;

    int nCmp = 0;
    int nBad = 0;

    // Per-cycle observations of the latest operation (bit k = cycle k after acceptance)
    logic [15:0] doneM, rvM, wrM, oeM, nnM, bstM, rdyM;
    logic [3:0]  cmd0;
    logic [12:0] arg0;
    logic [1:0]  ban0;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nCmp++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge with the engine idle; returns at a falling edge
    task automatic runOp(input logic [2:0] op, input logic [1:0] bank, input logic [12:0] addr,
                         input logic ap, input logic [9:0] len, input int ncyc);
        checkVal("ready before op", {63'd0, ReqReady}, 64'd1);
        ReqValid = 1'b1; ReqOp = op; ReqBank = bank; ReqAddr = addr;
        ReqAutoPre = ap; ReqLen = len;
        @(negedge Clk);
        ReqValid = 1'b0; ReqOp = 3'd0; ReqBank = '0; ReqAddr = '0; ReqAutoPre = 1'b0; ReqLen = '0;
        doneM = '0; rvM = '0; wrM = '0; oeM = '0; nnM = '0; bstM = '0; rdyM = '0;
        for (int k = 0; k < ncyc; k++) begin
            SdramToChipDqIn = 32'hD000_0000 + 32'(k);
            WrData          = 32'hA500_0000 + 32'(k);
            WrMask          = 4'(k);
            #1;
            if (k == 0) begin
                cmd0 = SdramToChipCmd; arg0 = SdramToChipArg; ban0 = SdramToChipBan;
            end
            doneM[k] = Done;
            rvM[k]   = RdDataValid;
            wrM[k]   = WrDataReady;
            oeM[k]   = SdramDqOe;
            nnM[k]   = (SdramToChipCmd != 4'b0111);
            bstM[k]  = (SdramToChipCmd == 4'b0110);
            rdyM[k]  = ReqReady;
            if (RdDataValid) checkVal("rd data", {32'd0, RdData}, {32'd0, 32'hD000_0000 + 32'(k)});
            if (WrDataReady) begin
                checkVal("wr dq", {32'd0, SdramToChipDq}, {32'd0, 32'hA500_0000 + 32'(k)});
                checkVal("wr dqm", {60'd0, SdramToChipDqm}, {60'd0, 4'(k)});
            end
            @(negedge Clk);
        end
    endtask

    task automatic expectOp(input string tag, input logic [3:0] cmd, input logic [12:0] arg,
                            input logic [1:0] ban, input logic [15:0] done, input logic [15:0] rv,
                            input logic [15:0] wr, input logic [15:0] bst, input logic [15:0] nn,
                            input logic [15:0] rdy);
        checkVal($sformatf("%s cmd", tag),   {60'd0, cmd0}, {60'd0, cmd});
        checkVal($sformatf("%s arg", tag),   {51'd0, arg0}, {51'd0, arg});
        checkVal($sformatf("%s ban", tag),   {62'd0, ban0}, {62'd0, ban});
        checkVal($sformatf("%s done", tag),  {48'd0, doneM}, {48'd0, done});
        checkVal($sformatf("%s rvalid", tag), {48'd0, rvM}, {48'd0, rv});
        checkVal($sformatf("%s wready", tag), {48'd0, wrM}, {48'd0, wr});
        checkVal($sformatf("%s dqoe", tag),  {48'd0, oeM}, {48'd0, wr});
        checkVal($sformatf("%s bst", tag),   {48'd0, bstM}, {48'd0, bst});
        checkVal($sformatf("%s non-nop", tag), {48'd0, nnM}, {48'd0, nn});
        checkVal($sformatf("%s ready", tag), {48'd0, rdyM}, {48'd0, rdy});
    endtask

    initial begin
        Rest = 1'b1; ReqValid = 1'b0; ReqOp = '0; ReqBank = '0; ReqAddr = '0;
        ReqAutoPre = 1'b0; ReqLen = '0; WrData = '0; WrMask = '0;
        SdramToChipDqIn = 32'hFFFF_FFFF;

        repeat (3) @(negedge Clk);
        #1;
        checkVal("reset ready", {63'd0, ReqReady}, 64'd0);
        checkVal("reset cmd", {60'd0, SdramToChipCmd}, 64'h7);
        checkVal("reset arg", {51'd0, SdramToChipArg}, 64'd0);
        checkVal("reset done", {63'd0, Done}, 64'd0);
        checkVal("reset rddata", {32'd0, RdData}, 64'd0);
        checkVal("reset dqoe", {63'd0, SdramDqOe}, 64'd0);
        Rest = 1'b0;
        #1;
        checkVal("ready after reset", {63'd0, ReqReady}, 64'd1);
        @(negedge Clk);

        // MRS BL4 CL3
        runOp(3'd0, 2'd0, 13'h032, 1'b0, 10'd0, 4);
        expectOp("mrs", 4'b0000, 13'h032, 2'd0, 16'h0002, 16'h0, 16'h0, 16'h0, 16'h0001, 16'h000C);
        // ACT bank 2 row 0x1A5
        runOp(3'd2, 2'd2, 13'h1A5, 1'b0, 10'd0, 4);
        expectOp("act", 4'b0011, 13'h1A5, 2'd2, 16'h0002, 16'h0, 16'h0, 16'h0, 16'h0001, 16'h000C);
        // READ BL4 CL3 col 0x10
        runOp(3'd3, 2'd1, 13'h010, 1'b0, 10'd0, 9);
        expectOp("rd bl4", 4'b0101, 13'h010, 2'd1, 16'h0040, 16'h0078, 16'h0, 16'h0, 16'h0001,
                 16'h0180);
        // MRS BL8 CL2, then WRITE with auto-precharge
        runOp(3'd0, 2'd0, 13'h023, 1'b0, 10'd0, 3);
        expectOp("mrs bl8", 4'b0000, 13'h023, 2'd0, 16'h0002, 16'h0, 16'h0, 16'h0, 16'h0001,
                 16'h0004);
        runOp(3'd4, 2'd3, 13'h01F, 1'b1, 10'd0, 14);
        expectOp("wr bl8 ap", 4'b0100, 13'h41F, 2'd3, 16'h0800, 16'h0, 16'h00FF, 16'h0, 16'h0001,
                 16'h3000);
        // MRS full page CL2, then full-page READ and WRITE of 5 beats
        runOp(3'd0, 2'd0, 13'h027, 1'b0, 10'd0, 3);
        expectOp("mrs fp", 4'b0000, 13'h027, 2'd0, 16'h0002, 16'h0, 16'h0, 16'h0, 16'h0001,
                 16'h0004);
        runOp(3'd3, 2'd0, 13'h005, 1'b1, 10'd5, 9);
        expectOp("rd fp", 4'b0101, 13'h005, 2'd0, 16'h0040, 16'h007C, 16'h0, 16'h0020, 16'h0021,
                 16'h0180);
        runOp(3'd4, 2'd2, 13'h007, 1'b0, 10'd5, 10);
        expectOp("wr fp", 4'b0100, 13'h007, 2'd2, 16'h0080, 16'h0, 16'h001F, 16'h0020, 16'h0021,
                 16'h0300);
        // Reserved op: no command, Done next cycle
        runOp(3'd6, 2'd1, 13'h123, 1'b0, 10'd0, 3);
        expectOp("reserved", 4'b0111, 13'h000, 2'd0, 16'h0001, 16'h0, 16'h0, 16'h0, 16'h0000,
                 16'h0006);

        // REFRESH aborted by reset on cycle 3
        checkVal("ready before ref", {63'd0, ReqReady}, 64'd1);
        ReqValid = 1'b1; ReqOp = 3'd5;
        @(negedge Clk);
        ReqValid = 1'b0; ReqOp = 3'd0;
        doneM = '0;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (k == 0) checkVal("ref cmd", {60'd0, SdramToChipCmd}, 64'h1);
            doneM[k] = Done;
            if (k == 3) Rest = 1'b1;
            @(negedge Clk);
        end
        #1;
        checkVal("abort cmd", {60'd0, SdramToChipCmd}, 64'h7);
        checkVal("abort arg", {51'd0, SdramToChipArg}, 64'd0);
        checkVal("abort ban", {62'd0, SdramToChipBan}, 64'd0);
        checkVal("abort ready", {63'd0, ReqReady}, 64'd0);
        checkVal("abort dqoe", {63'd0, SdramDqOe}, 64'd0);
        checkVal("abort wready", {63'd0, WrDataReady}, 64'd0);
        checkVal("abort rvalid", {63'd0, RdDataValid}, 64'd0);
        doneM[4] = Done;
        Rest = 1'b0;
        @(negedge Clk);
        for (int k = 5; k < 10; k++) begin
            #1;
            doneM[k] = Done;
            @(negedge Clk);
        end
        checkVal("abort no done", {48'd0, doneM}, 64'd0);
        // Mode back to BL1/CL2: ReqLen must be ignored
        runOp(3'd3, 2'd1, 13'h003, 1'b0, 10'd5, 5);
        expectOp("rd after rst", 4'b0101, 13'h003, 2'd1, 16'h0004, 16'h0004, 16'h0, 16'h0, 16'h0001,
                 16'h0018);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
